// File: rtl/fifo_pkg.sv
// Pointer helpers shared by the write- and read-side FIFO controllers.
// Functions work on a fixed maximum width; callers zero-extend and truncate.
package fifo_pkg;

    localparam int MAX_PTR_W = 13;

    typedef logic [MAX_PTR_W-1:0] ptr_t;

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
        for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into this clock domain.
module ptr_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/wr_ptr_full_ctrl.sv
// Write-side async FIFO controller: binary/Gray write pointer, look-ahead full,
// occupancy, almost-full and sticky overflow, all registered in the write domain.
module wr_ptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_LEVEL = depth_of(ADDR_WIDTH) - 2
) (
    input  logic                  w_clk,
    input  logic                  w_rst,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   r_ptr,
    input  logic                  wovf_clr,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   w_ptr,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wcount,
    output logic                  wovf
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AFULL_CMP = PW'(AFULL_LEVEL);

    logic [PW-1:0] r_bin;
    logic [PW-1:0] r_gray;
    logic          r_full;
    logic          r_afull;
    logic [PW-1:0] r_count;
    logic          r_ovf;

    logic [PW-1:0] w_rq_ptr;
    logic          w_wen;
    logic [PW-1:0] w_bin_next;
    logic [PW-1:0] w_gray_next;
    logic [PW-1:0] w_rq_bin;
    logic [PW-1:0] w_count_next;
    logic          w_full_next;
    logic          w_afull_next;

    ptr_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .i_clk   (w_clk),
        .i_rst_n (w_rst),
        .i_d     (r_ptr),
        .o_q     (w_rq_ptr)
    );

    // winc is a request qualified by wfull in the same cycle: accepted only while
    // wfull=0; a refused request changes nothing except setting wovf.
    assign w_wen       = winc & ~r_full;
    assign w_bin_next  = r_bin + {{(PW-1){1'b0}}, w_wen};
    assign w_gray_next = PW'(bin2gray(ptr_t'(w_bin_next)));
    assign w_rq_bin    = PW'(gray2bin(ptr_t'(w_rq_ptr)));

    // Full when the next write pointer has lapped the synchronised read pointer once.
    assign w_full_next  = (w_gray_next == {~w_rq_ptr[PW-1:PW-2], w_rq_ptr[PW-3:0]});
    assign w_count_next = w_bin_next - w_rq_bin;
    assign w_afull_next = (w_count_next >= AFULL_CMP);

    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            r_bin   <= '0;
            r_gray  <= '0;
            r_full  <= 1'b0;
            r_afull <= 1'b0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_bin   <= w_bin_next;
            r_gray  <= w_gray_next;
            r_full  <= w_full_next;
            r_afull <= w_afull_next;
            r_count <= w_count_next;
            r_ovf   <= (winc & r_full) | (r_ovf & ~wovf_clr);
        end
    end

    assign waddr        = r_bin[ADDR_WIDTH-1:0];
    assign w_ptr        = r_gray;
    assign wfull        = r_full;
    assign walmost_full = r_afull;
    assign wcount       = r_count;
    assign wovf         = r_ovf;

endmodule
